// File: rtl/spi_miso_tx_pkg.sv
// Shared constants for the host-link SPI transmit path.
//   SPI_FILL_WORD : word sent when the transmit FIFO is empty at a word load
//   SPI_WORD_BITS : bits per SPI word
//   SMT_*         : transmit state machine encodings
package spi_miso_tx_pkg;

  localparam logic [15:0] SPI_FILL_WORD = 16'hFFFF;
  localparam int unsigned SPI_WORD_BITS = 16;

  localparam logic [1:0] SMT_IDLE  = 2'd0;
  localparam logic [1:0] SMT_LOAD  = 2'd1;
  localparam logic [1:0] SMT_SHIFT = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
//   clk, rst_n        : clock, synchronous active-low reset
//   push, push_data   : enqueue (ignored while full)
//   pop               : dequeue the head (ignored while empty)
//   head              : current head word, valid while !empty
//   full, empty, level: occupancy status
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_miso_tx.sv
// Host-link SPI transmit end (mode 0, MSB first).
//   cpu_clk, cpu_rst_n        : sole clock, synchronous active-low reset
//   wr_data, wr_en            : eCPU write port into the transmit FIFO
//   full, level               : FIFO status
//   clr_flags, ovr, udr       : sticky overrun / underrun flags and their clear
//   spi_sclk, spi_cs_n        : asynchronous host bus inputs
//   spi_miso, spi_miso_oe     : serial data and pad output enable
module spi_miso_tx
  import spi_miso_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst_n,
  input  logic [15:0]   wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic [AW:0]   level,
  input  logic          clr_flags,
  output logic          ovr,
  output logic          udr,
  input  logic          spi_sclk,
  input  logic          spi_cs_n,
  output logic          spi_miso,
  output logic          spi_miso_oe
);

  localparam int unsigned BcW = $clog2(SPI_WORD_BITS);

  // [0],[1] synchronize; [2] is the previous synchronized value for edge detect.
  logic [2:0]     sclk_s, cs_s;
  logic           sclk_rise, sclk_fall, cs_start, cs_end;

  logic [1:0]     state_q, state_d;
  logic [15:0]    shreg_q, shreg_d;
  logic [BcW-1:0] bit_cnt_q, bit_cnt_d;
  logic           ovr_q, ovr_d, udr_q, udr_d;

  logic [15:0]    fifo_head;
  logic           fifo_empty, fifo_full;
  logic           load_word, pop;

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_start  = ~cs_s[1] & cs_s[2];
  assign cs_end    = cs_s[1] & ~cs_s[2];

  // A word is loaded in LOAD, or on the falling edge after the 16th rising edge.
  // A CS deassert in the same cycle wins, so nothing is popped then.
  assign load_word = ~cs_end &
                     ((state_q == SMT_LOAD) |
                      ((state_q == SMT_SHIFT) & sclk_fall & (bit_cnt_q == '0)));
  assign pop       = load_word & ~fifo_empty;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (cpu_clk),
    .rst_n     (cpu_rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (cs_end) begin
      state_d   = SMT_IDLE;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        SMT_IDLE: if (cs_start) state_d = SMT_LOAD;
        SMT_LOAD: begin
          state_d   = SMT_SHIFT;
          bit_cnt_d = '0;
        end
        SMT_SHIFT: begin
          if (sclk_rise) bit_cnt_d = bit_cnt_q + BcW'(1);
          if (sclk_fall && bit_cnt_q != '0) shreg_d = {shreg_q[14:0], 1'b0};
        end
        default: state_d = SMT_IDLE;
      endcase
    end
    if (load_word) shreg_d = fifo_empty ? SPI_FILL_WORD : fifo_head;
  end

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    ovr_d = ovr_q;
    udr_d = udr_q;
    if (clr_flags) begin
      ovr_d = 1'b0;
      udr_d = 1'b0;
    end
    if (wr_en & fifo_full)      ovr_d = 1'b1;
    if (load_word & fifo_empty) udr_d = 1'b1;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      sclk_s    <= 3'b000;
      cs_s      <= 3'b111;
      state_q   <= SMT_IDLE;
      shreg_q   <= SPI_FILL_WORD;
      bit_cnt_q <= '0;
      ovr_q     <= 1'b0;
      udr_q     <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[1:0], spi_sclk};
      cs_s      <= {cs_s[1:0], spi_cs_n};
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ovr_q     <= ovr_d;
      udr_q     <= udr_d;
    end
  end

  assign full        = fifo_full;
  assign ovr         = ovr_q;
  assign udr         = udr_q;
  assign spi_miso_oe = (state_q != SMT_IDLE);
  assign spi_miso    = (state_q == SMT_IDLE) ? 1'b1 : shreg_q[15];

endmodule

// File: tb/tb_spi_miso_tx.sv
module tb_spi_miso_tx;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst_n;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic          full;
  logic [AW:0]   level;
  logic          clr_flags;
  logic          ovr, udr;
  logic          spi_sclk, spi_cs_n;
  logic          spi_miso, spi_miso_oe;

  int n_checks = 0;
  int n_fail   = 0;

  spi_miso_tx #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst_n   (cpu_rst_n),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .level       (level),
    .clr_flags   (clr_flags),
    .ovr         (ovr),
    .udr         (udr),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    wait_cycles(1);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    wait_cycles(1);
    clr_flags = 1'b0;
    wait_cycles(1);
  endtask

  task automatic cs_assert();
    spi_cs_n = 1'b0;
    wait_cycles(8);
  endtask

  // Releasing SCLK together with CS means the trailing fall never loads a word.
  task automatic cs_deassert();
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    wait_cycles(6);
  endtask

  // Host side of mode 0: sample MISO on each rising edge, 5 cpu_clk per phase.
  task automatic clock_bits(input int n, input bit last, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b1;
      got = {got[14:0], spi_miso};
      wait_cycles(5);
      if (!(last && i == n - 1)) begin
        spi_sclk = 1'b0;
        wait_cycles(5);
      end
    end
  endtask

  logic [15:0] rx;

  initial begin
    cpu_rst_n = 1'b0;
    wr_data   = '0;
    wr_en     = 1'b0;
    clr_flags = 1'b0;
    spi_sclk  = 1'b0;
    spi_cs_n  = 1'b1;
    wait_cycles(3);
    cpu_rst_n = 1'b1;
    wait_cycles(2);

    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_ovr", 32'(ovr), 32'd0);
    check_eq("rst_udr", 32'(udr), 32'd0);
    check_eq("rst_miso", 32'(spi_miso), 32'd1);
    check_eq("rst_oe", 32'(spi_miso_oe), 32'd0);

    // Single word
    write_word(16'hA5C3);
    check_eq("t1_level_wr", 32'(level), 32'd1);
    cs_assert();
    check_eq("t1_oe", 32'(spi_miso_oe), 32'd1);
    check_eq("t1_level_pop", 32'(level), 32'd0);
    clock_bits(16, 1'b1, rx);
    check_eq("t1_word", 32'(rx), 32'hA5C3);
    cs_deassert();
    check_eq("t1_udr", 32'(udr), 32'd0);
    check_eq("t1_oe_idle", 32'(spi_miso_oe), 32'd0);
    check_eq("t1_miso_idle", 32'(spi_miso), 32'd1);

    // Back-to-back words
    write_word(16'h1234);
    write_word(16'hFEDC);
    check_eq("t2_level_wr", 32'(level), 32'd2);
    cs_assert();
    check_eq("t2_level_pop1", 32'(level), 32'd1);
    clock_bits(16, 1'b0, rx);
    check_eq("t2_word0", 32'(rx), 32'h1234);
    check_eq("t2_level_pop2", 32'(level), 32'd0);
    clock_bits(16, 1'b1, rx);
    check_eq("t2_word1", 32'(rx), 32'hFEDC);
    cs_deassert();
    check_eq("t2_udr", 32'(udr), 32'd0);

    // Underrun
    cs_assert();
    check_eq("t3_udr_set", 32'(udr), 32'd1);
    clock_bits(16, 1'b1, rx);
    check_eq("t3_fill", 32'(rx), 32'hFFFF);
    cs_deassert();
    pulse_clr();
    check_eq("t3_udr_clr", 32'(udr), 32'd0);

    // Overrun
    for (int i = 0; i < 16; i++) write_word(16'h0100 + 16'(i));
    check_eq("t4_full", 32'(full), 32'd1);
    check_eq("t4_level16", 32'(level), 32'd16);
    check_eq("t4_ovr_pre", 32'(ovr), 32'd0);
    write_word(16'hDEAD);
    check_eq("t4_ovr", 32'(ovr), 32'd1);
    check_eq("t4_level_ovr", 32'(level), 32'd16);
    cs_assert();
    check_eq("t4_full_pop", 32'(full), 32'd0);
    for (int w = 0; w < 16; w++) begin
      clock_bits(16, (w == 15), rx);
      check_eq($sformatf("t4_word%0d", w), 32'(rx), 32'h0100 + 32'(w));
    end
    cs_deassert();
    check_eq("t4_level_end", 32'(level), 32'd0);
    check_eq("t4_udr", 32'(udr), 32'd0);
    pulse_clr();
    check_eq("t4_ovr_clr", 32'(ovr), 32'd0);

    // Partial word discarded on CS deassert
    write_word(16'h8001);
    write_word(16'h7FFE);
    cs_assert();
    clock_bits(5, 1'b1, rx);
    check_eq("t5_partial", 32'(rx), 32'h0010);
    cs_deassert();
    check_eq("t5_oe_idle", 32'(spi_miso_oe), 32'd0);
    check_eq("t5_miso_idle", 32'(spi_miso), 32'd1);
    check_eq("t5_level", 32'(level), 32'd1);
    cs_assert();
    clock_bits(16, 1'b1, rx);
    check_eq("t5_word", 32'(rx), 32'h7FFE);
    cs_deassert();
    check_eq("t5_udr", 32'(udr), 32'd0);

    // Reset mid-word
    write_word(16'h1111);
    write_word(16'h2222);
    write_word(16'h3333);
    cs_assert();
    clock_bits(5, 1'b1, rx);
    check_eq("t6_oe_pre", 32'(spi_miso_oe), 32'd1);
    cpu_rst_n = 1'b0;
    wait_cycles(1);
    check_eq("t6_level", 32'(level), 32'd0);
    check_eq("t6_oe", 32'(spi_miso_oe), 32'd0);
    check_eq("t6_miso", 32'(spi_miso), 32'd1);
    check_eq("t6_full", 32'(full), 32'd0);
    spi_cs_n  = 1'b1;
    spi_sclk  = 1'b0;
    cpu_rst_n = 1'b1;
    wait_cycles(6);
    check_eq("t6_udr_pre", 32'(udr), 32'd0);
    cs_assert();
    clock_bits(16, 1'b1, rx);
    check_eq("t6_fill", 32'(rx), 32'hFFFF);
    cs_deassert();
    check_eq("t6_udr", 32'(udr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
